plab4_net_mux: RTL and testbench

- Two-domain merge point: the inverse of the domain demux.
- Takes two val/rdy message streams, one per security domain (d1 = domain 0, d2 = domain 1), each with separate control and data fields.
- Arbitrates between them round-robin and presents one output stream through a single-entry registered buffer.
- Emits a `domain` tag naming the owner of the buffered message, so a downstream demux can route responses back to the right domain.

---
 rtl/plab4_net_mux.sv | 123 ++++++++++++
 tb/tb_plab4_net_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab4_net_mux.sv
// plab4_net_mux: merges two per-domain val/rdy message streams into one
// output stream. A round-robin arbiter picks at most one domain per cycle
// and the winner's message lands in a single-entry registered buffer. The
// buffered message carries a domain tag so responses can be routed back.
//
// Handshake rule for every port pair: a transfer happens on a rising clock
// edge exactly when val and rdy are both high during the preceding cycle.
// A source that raises val must hold val and its message stable until it
// sees rdy; rdy may rise or fall freely and never depends on message
// contents.

module plab4_net_mux #(
   parameter int p_msg_cnbits = 32,
   parameter int p_msg_dnbits = 32
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    in_val_d1,
   output logic                    in_rdy_d1,
   input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
   input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

   input  logic                    in_val_d2,
   output logic                    in_rdy_d2,
   input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
   input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [p_msg_cnbits-1:0] out_msg_control,
   output logic [p_msg_dnbits-1:0] out_msg_data,
   output logic                    domain
);

   // Buffer and arbitration state
   logic                    full;
   logic                    buf_dom;
   logic [p_msg_cnbits-1:0] buf_ctrl;
   logic [p_msg_dnbits-1:0] buf_data;
   logic                    prio;       // 0: d1 wins a tie, 1: d2 wins

   // Combinational control
   logic                    can_accept;
   logic                    grant_d1;
   logic                    grant_d2;
   logic                    in_fire;
   logic                    out_fire;
   logic [p_msg_cnbits-1:0] sel_ctrl;
   logic [p_msg_dnbits-1:0] sel_data;

   // Round-robin grant; the buffer may take a message when empty or draining
   always_comb begin
      can_accept = !full || out_rdy;
      grant_d1   = 1'b0;
      grant_d2   = 1'b0;
      if (can_accept) begin
         if (in_val_d1 && in_val_d2) begin
            grant_d1 = !prio;
            grant_d2 = prio;
         end else begin
            grant_d1 = in_val_d1;
            grant_d2 = in_val_d2;
         end
      end
   end

   // Ready is forced low while reset is held so nothing is offered then
   always_comb begin
      in_rdy_d1 = !reset && grant_d1;
      in_rdy_d2 = !reset && grant_d2;
      in_fire   = (in_val_d1 && in_rdy_d1) || (in_val_d2 && in_rdy_d2);
      out_fire  = full && out_rdy;
   end

   // Masked select: the ungranted domain's fields are zeroed before the
   // mux so they cannot leak into the buffer even transiently
   always_comb begin
      sel_ctrl = ({p_msg_cnbits{grant_d1}} & in_msg_control_d1)
               | ({p_msg_cnbits{grant_d2}} & in_msg_control_d2);
      sel_data = ({p_msg_dnbits{grant_d1}} & in_msg_data_d1)
               | ({p_msg_dnbits{grant_d2}} & in_msg_data_d2);
   end

   // Buffer: fill on input handshake (even while draining), scrub on a
   // drain without refill, hold otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         full     <= 1'b0;
         buf_dom  <= 1'b0;
         buf_ctrl <= '0;
         buf_data <= '0;
      end else if (in_fire) begin
         full     <= 1'b1;
         buf_dom  <= grant_d2;
         buf_ctrl <= sel_ctrl;
         buf_data <= sel_data;
      end else if (out_fire) begin
         full     <= 1'b0;
         buf_dom  <= 1'b0;
         buf_ctrl <= '0;
         buf_data <= '0;
      end
   end

   // Priority pointer flips on every accepted message only
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio <= 1'b0;
      end else if (in_fire) begin
         prio <= ~prio;
      end
   end

   // Outputs come straight from registers
   always_comb begin
      out_val         = full;
      domain          = buf_dom;
      out_msg_control = buf_ctrl;
      out_msg_data    = buf_data;
   end

endmodule

// File: tb/tb_plab4_net_mux.sv
// Directed bench for plab4_net_mux: reset, round-robin, backpressure,
// scrub-on-drain, domain isolation and single-requester streaming.

module tb_plab4_net_mux;

  logic        clk;
  logic        reset;
  logic        in_val_d1;
  logic        in_rdy_d1;
  logic [31:0] in_msg_control_d1;
  logic [31:0] in_msg_data_d1;
  logic        in_val_d2;
  logic        in_rdy_d2;
  logic [31:0] in_msg_control_d2;
  logic [31:0] in_msg_data_d2;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_msg_control;
  logic [31:0] out_msg_data;
  logic        domain;

  int checks;
  int passes;

  plab4_net_mux #(.p_msg_cnbits(32), .p_msg_dnbits(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_val_d1         (in_val_d1),
    .in_rdy_d1         (in_rdy_d1),
    .in_msg_control_d1 (in_msg_control_d1),
    .in_msg_data_d1    (in_msg_data_d1),
    .in_val_d2         (in_val_d2),
    .in_rdy_d2         (in_rdy_d2),
    .in_msg_control_d2 (in_msg_control_d2),
    .in_msg_data_d2    (in_msg_data_d2),
    .out_val           (out_val),
    .out_rdy           (out_rdy),
    .out_msg_control   (out_msg_control),
    .out_msg_data      (out_msg_data),
    .domain            (domain)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic idle_inputs();
    in_val_d1 = 1'b0; in_msg_control_d1 = '0; in_msg_data_d1 = '0;
    in_val_d2 = 1'b0; in_msg_control_d2 = '0; in_msg_data_d2 = '0;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    out_rdy = 1'b0;
    next_edge();
    reset = 1'b0;
  endtask

  task automatic drive_d1(input logic [31:0] c, input logic [31:0] d);
    in_val_d1 = 1'b1; in_msg_control_d1 = c; in_msg_data_d1 = d;
  endtask

  task automatic drive_d2(input logic [31:0] c, input logic [31:0] d);
    in_val_d2 = 1'b1; in_msg_control_d2 = c; in_msg_data_d2 = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    out_rdy = 1'b1;
    next_edge();
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control, in_rdy_d1, in_rdy_d2} !== 68'd0)
      $display("FAIL reset_state: val=%b dom=%b data=%h ctrl=%h rdy=%b%b, want all 0",
               out_val, domain, out_msg_data, out_msg_control, in_rdy_d1, in_rdy_d2);
    else passes++;
    reset = 1'b0;
    // fill with 0xDEADBEEF and hold it
    out_rdy = 1'b0;
    drive_d1(32'h0000_00C1, 32'hDEAD_BEEF);
    next_edge();
    idle_inputs();
    checks++;
    if ({out_val, domain, out_msg_data} !== {1'b1, 1'b0, 32'hDEAD_BEEF})
      $display("FAIL reset_prefill: val=%b dom=%b data=%h, want 1/0/deadbeef",
               out_val, domain, out_msg_data);
    else passes++;
    // asynchronous reset mid-cycle
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== 66'd0)
      $display("FAIL reset_async: val=%b dom=%b data=%h ctrl=%h, want all 0",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
    #1 reset = 1'b0;
    next_edge();
    // first d2 message after release
    out_rdy = 1'b1;
    drive_d2(32'h0000_00C2, 32'h0000_0022);
    #1;
    checks++;
    if ({in_rdy_d1, in_rdy_d2} !== 2'b01)
      $display("FAIL reset_first_rdy: rdy=%b%b, want 01", in_rdy_d1, in_rdy_d2);
    else passes++;
    next_edge();
    idle_inputs();
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== {1'b1, 1'b1, 32'h22, 32'hC2})
      $display("FAIL reset_first_msg: val=%b dom=%b data=%h ctrl=%h, want 1/1/22/c2",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
    next_edge();
  endtask

  task automatic test_round_robin();
    logic [31:0] d1_q[3];
    logic [31:0] d2_q[3];
    logic [31:0] exp_data[6];
    logic        exp_dom[6];
    int i1, i2;
    logic g1, g2;
    d1_q = '{32'h11, 32'h12, 32'h13};
    d2_q = '{32'h21, 32'h22, 32'h23};
    exp_data = '{32'h11, 32'h21, 32'h12, 32'h22, 32'h13, 32'h23};
    exp_dom  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    out_rdy = 1'b1;
    i1 = 0; i2 = 0;
    for (int c = 0; c < 6; c++) begin
      idle_inputs();
      if (i1 < 3) drive_d1(d1_q[i1] ^ 32'hC0DE_0000, d1_q[i1]);
      if (i2 < 3) drive_d2(d2_q[i2] ^ 32'hC0DE_0000, d2_q[i2]);
      #1;
      g1 = in_rdy_d1;
      g2 = in_rdy_d2;
      checks++;
      if ({g1, g2} !== (exp_dom[c] ? 2'b01 : 2'b10))
        $display("FAIL rr_grant[%0d]: rdy=%b%b, want %b", c, g1, g2,
                 exp_dom[c] ? 2'b01 : 2'b10);
      else passes++;
      next_edge();
      checks++;
      if ({out_val, domain, out_msg_data, out_msg_control} !==
          {1'b1, exp_dom[c], exp_data[c], exp_data[c] ^ 32'hC0DE_0000})
        $display("FAIL rr_out[%0d]: val=%b dom=%b data=%h ctrl=%h, want 1/%b/%h",
                 c, out_val, domain, out_msg_data, out_msg_control, exp_dom[c], exp_data[c]);
      else passes++;
      if (g1) i1++;
      if (g2) i2++;
    end
    idle_inputs();
    next_edge();
    checks++;
    if (out_val !== 1'b0)
      $display("FAIL rr_drain: val=%b, want 0", out_val);
    else passes++;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_rdy = 1'b0;
    drive_d1(32'h0000_00A0, 32'h0000_00A5);
    next_edge();
    idle_inputs();
    drive_d2(32'h0000_00B0, 32'h0000_00B6);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({in_rdy_d1, in_rdy_d2} !== 2'b00)
        $display("FAIL bp_rdy[%0d]: rdy=%b%b, want 00", c, in_rdy_d1, in_rdy_d2);
      else passes++;
      next_edge();
      checks++;
      if ({out_val, domain, out_msg_data, out_msg_control} !== {1'b1, 1'b0, 32'hA5, 32'hA0})
        $display("FAIL bp_hold[%0d]: val=%b dom=%b data=%h ctrl=%h, want 1/0/a5/a0",
                 c, out_val, domain, out_msg_data, out_msg_control);
      else passes++;
    end
    out_rdy = 1'b1;
    #1;
    checks++;
    if ({in_rdy_d1, in_rdy_d2} !== 2'b01)
      $display("FAIL bp_release_rdy: rdy=%b%b, want 01", in_rdy_d1, in_rdy_d2);
    else passes++;
    next_edge();
    idle_inputs();
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== {1'b1, 1'b1, 32'hB6, 32'hB0})
      $display("FAIL bp_release_out: val=%b dom=%b data=%h ctrl=%h, want 1/1/b6/b0",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
    next_edge();
  endtask

  task automatic test_scrub();
    do_reset();
    out_rdy = 1'b1;
    drive_d2(32'h0000_0077, 32'h0000_5A5A);
    next_edge();
    idle_inputs();
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== {1'b1, 1'b1, 32'h5A5A, 32'h77})
      $display("FAIL scrub_msg: val=%b dom=%b data=%h ctrl=%h, want 1/1/5a5a/77",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
    next_edge();
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== 66'd0)
      $display("FAIL scrub_clear: val=%b dom=%b data=%h ctrl=%h, want all 0",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
  endtask

  task automatic test_isolation();
    do_reset();
    out_rdy = 1'b1;
    drive_d1(32'h0000_0D01, 32'h0000_0001);
    drive_d2(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    #1;
    checks++;
    if ({in_rdy_d1, in_rdy_d2} !== 2'b10)
      $display("FAIL iso_rdy: rdy=%b%b, want 10", in_rdy_d1, in_rdy_d2);
    else passes++;
    next_edge();
    in_val_d1 = 1'b0;
    out_rdy = 1'b0;
    checks++;
    if ({out_val, domain, out_msg_data, out_msg_control} !== {1'b1, 1'b0, 32'h1, 32'hD01})
      $display("FAIL iso_out: val=%b dom=%b data=%h ctrl=%h, want 1/0/00000001/d01",
               out_val, domain, out_msg_data, out_msg_control);
    else passes++;
    next_edge();
    checks++;
    if ({domain, out_msg_data} !== {1'b0, 32'h1})
      $display("FAIL iso_hold: dom=%b data=%h, want 0/00000001", domain, out_msg_data);
    else passes++;
    out_rdy = 1'b1;
    next_edge();
    idle_inputs();
    checks++;
    if ({out_val, domain, out_msg_data} !== {1'b1, 1'b1, 32'hFFFF_FFFF})
      $display("FAIL iso_d2_later: val=%b dom=%b data=%h, want 1/1/ffffffff",
               out_val, domain, out_msg_data);
    else passes++;
    next_edge();
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      drive_d1(32'h0000_0E00 + c, 32'h0000_0100 + c);
      #1;
      checks++;
      if (in_rdy_d1 !== 1'b1)
        $display("FAIL b2b_rdy[%0d]: rdy=%b, want 1", c, in_rdy_d1);
      else passes++;
      next_edge();
      checks++;
      if ({out_val, domain, out_msg_data, out_msg_control} !==
          {1'b1, 1'b0, 32'h0000_0100 + c, 32'h0000_0E00 + c})
        $display("FAIL b2b_out[%0d]: val=%b dom=%b data=%h ctrl=%h, want 1/0/%h",
                 c, out_val, domain, out_msg_data, out_msg_control, 32'h0000_0100 + c);
      else passes++;
    end
    idle_inputs();
    next_edge();
    checks++;
    if ({out_val, out_msg_data} !== 33'd0)
      $display("FAIL b2b_drain: val=%b data=%h, want 0/0", out_val, out_msg_data);
    else passes++;
  endtask

  // sequence and final report
  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_scrub();
    test_isolation();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
